// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type and forwarding-select constants for hazard_unit.
package hazard_pkg;
  localparam int MAX_IDX_W = 8;
  localparam int DEPTH_DEF = 3;
  localparam int FWD_REGFILE = 0;
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  localparam int FWD_SEL_W = fwd_sel_w(DEPTH_DEF);
  typedef struct packed {
    logic valid;
    logic [MAX_IDX_W-1:0] dst;
    logic is_load;
  } sb_entry_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-first search of the scoreboard for one source register; ports stages/src in, hit/ready/sel out.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LOAD_RDY_STAGE = 1,
  parameter int SW = 2
) (
  input  sb_entry_t [DEPTH-1:0] stages,
  input  logic [MAX_IDX_W-1:0]  src,
  output logic                  hit,
  output logic                  ready,
  output logic [SW-1:0]         sel
);
  always_comb begin
    hit = 1'b0;
    ready = 1'b0;
    sel = SW'(FWD_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--)
      if (stages[k].valid && stages[k].dst == src) begin
        hit = 1'b1;
        ready = !stages[k].is_load || k >= LOAD_RDY_STAGE;
        sel = SW'(k + 1);
      end
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline scoreboard producing decode stall, per-source forwarding selects and a saturating stall counter; ports clk/rst, id_* decode info, flush_ixif in; id_ready, fwd_sel_rs/rt, stall_cnt out.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_IDX_W = 3,
  parameter int DEPTH = 3,
  parameter int LOAD_RDY_STAGE = 1,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_IDX_W-1:0]         id_rs,
  input  logic                         id_rs_used,
  input  logic [REG_IDX_W-1:0]         id_rt,
  input  logic                         id_rt_used,
  input  logic [REG_IDX_W-1:0]         id_dst,
  input  logic                         id_dst_valid,
  input  logic                         id_is_load,
  input  logic                         flush_ixif,
  output logic                         id_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rs,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_rt,
  output logic [CNT_W-1:0]             stall_cnt
);
  localparam int SW = $clog2(DEPTH + 1);
  sb_entry_t [DEPTH-1:0] stages;
  logic hit_rs, rdy_rs, hit_rt, rdy_rt, hz_rs, hz_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  hazard_match #(.DEPTH(DEPTH), .LOAD_RDY_STAGE(LOAD_RDY_STAGE), .SW(SW)) u_match_rs (
    .stages(stages), .src(MAX_IDX_W'(id_rs)), .hit(hit_rs), .ready(rdy_rs), .sel(sel_rs)
  );
  hazard_match #(.DEPTH(DEPTH), .LOAD_RDY_STAGE(LOAD_RDY_STAGE), .SW(SW)) u_match_rt (
    .stages(stages), .src(MAX_IDX_W'(id_rt)), .hit(hit_rt), .ready(rdy_rt), .sel(sel_rt)
  );
  // Without forwarding any in-flight producer blocks until it has retired.
  always_comb begin
    hz_rs = id_rs_used && hit_rs && (FWD_EN == 0 || !rdy_rs);
    hz_rt = id_rt_used && hit_rt && (FWD_EN == 0 || !rdy_rt);
    id_ready = !(hz_rs || hz_rt);
    fwd_sel_rs = (FWD_EN != 0 && id_valid && id_ready && id_rs_used && hit_rs) ? sel_rs : SW'(FWD_REGFILE);
    fwd_sel_rt = (FWD_EN != 0 && id_valid && id_ready && id_rt_used && hit_rt) ? sel_rt : SW'(FWD_REGFILE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
      stall_cnt <= '0;
    end else begin
      stages[0] <= '{valid: id_valid && id_ready && id_dst_valid && !flush_ixif,
                     dst: MAX_IDX_W'(id_dst), is_load: id_is_load};
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
      if (id_valid && !id_ready && !flush_ixif && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit (forwarding and non-forwarding builds) against an in-bench model.
module tb_hazard_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_rs_used = 0, id_rt_used = 0, id_dst_valid = 0, id_is_load = 0, flush_ixif = 0;
  logic [2:0] id_rs = 0, id_rt = 0, id_dst = 0;
  logic [1:0] rdy;
  logic [1:0] srs [2];
  logic [1:0] srt [2];
  logic [15:0] cnt [2];
  int checks = 0, errors = 0;
  // Model: per build (0 = forwarding, 1 = none), the writes issued 1, 2, 3 cycles ago.
  logic mv [2][3];
  logic [2:0] md [2][3];
  logic ml [2][3];
  int mcnt [2];
  logic erdy [2];
  always #5 clk = ~clk;
  hazard_unit #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_dst_valid(id_dst_valid),
    .id_is_load(id_is_load), .flush_ixif(flush_ixif), .id_ready(rdy[0]),
    .fwd_sel_rs(srs[0]), .fwd_sel_rt(srt[0]), .stall_cnt(cnt[0])
  );
  hazard_unit #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_dst_valid(id_dst_valid),
    .id_is_load(id_is_load), .flush_ixif(flush_ixif), .id_ready(rdy[1]),
    .fwd_sel_rs(srs[1]), .fwd_sel_rt(srt[1]), .stall_cnt(cnt[1])
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Youngest in-flight writer of s decides; loads become usable one cycle late.
  function automatic void look(input int f, input logic [2:0] s, input logic used, output logic hz, output int sel);
    hz = 0;
    sel = 0;
    if (!used) return;
    for (int age = 0; age < 3; age++)
      if (mv[f][age] && md[f][age] == s) begin
        hz = (f == 1) ? 1'b1 : (ml[f][age] && age < 1);
        sel = (f == 1) ? 0 : age + 1;
        return;
      end
  endfunction
  task automatic model_check();
    logic hs, ht;
    int ss, st;
    for (int f = 0; f < 2; f++) begin
      look(f, id_rs, id_rs_used, hs, ss);
      look(f, id_rt, id_rt_used, ht, st);
      erdy[f] = !(hs || ht);
      chk($sformatf("ready[%0d]", f), int'(rdy[f]), int'(erdy[f]));
      chk($sformatf("sel_rs[%0d]", f), int'(srs[f]), (id_valid && erdy[f]) ? ss : 0);
      chk($sformatf("sel_rt[%0d]", f), int'(srt[f]), (id_valid && erdy[f]) ? st : 0);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
                       input logic [2:0] dst, input logic dv, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_dst = dst; id_dst_valid = dv; id_is_load = ld; flush_ixif = fl;
    @(negedge clk);
    model_check();
  endtask
  task automatic adv();
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      if (rst) begin
        for (int a = 0; a < 3; a++) mv[f][a] = 0;
        mcnt[f] = 0;
      end else begin
        for (int a = 2; a > 0; a--) begin
          mv[f][a] = mv[f][a-1]; md[f][a] = md[f][a-1]; ml[f][a] = ml[f][a-1];
        end
        mv[f][0] = id_valid && erdy[f] && id_dst_valid && !flush_ixif;
        md[f][0] = id_dst;
        ml[f][0] = id_is_load;
        if (id_valid && !erdy[f] && !flush_ixif && mcnt[f] < 65535) mcnt[f]++;
      end
    end
    #1;
    for (int f = 0; f < 2; f++) chk($sformatf("stall_cnt[%0d]", f), int'(cnt[f]), mcnt[f]);
  endtask
  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    rst = 0;
  endtask
  initial begin
    for (int f = 0; f < 2; f++) begin
      mcnt[f] = 0;
      erdy[f] = 1;
      for (int a = 0; a < 3; a++) begin mv[f][a] = 0; md[f][a] = 0; ml[f][a] = 0; end
    end
    @(posedge clk);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset ready", int'(rdy[0]), 1);
    chk("reset sel_rs", int'(srs[0]), 0);
    chk("reset cnt", int'(cnt[0]), 0);
    // ADD r1 then consumer of r1 forwards from execute.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); adv();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0);
    chk("add-add ready", int'(rdy[0]), 1);
    chk("add-add sel_rs", int'(srs[0]), 1);
    adv();
    // Load-use: one stall then forward from stage 1.
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); adv();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0);
    chk("load-use stall", int'(rdy[0]), 0);
    adv();
    chk("load-use cnt", int'(cnt[0]), 1);
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0);
    chk("load-use ready", int'(rdy[0]), 1);
    chk("load-use sel", int'(srs[0]), 2);
    adv();
    // Producer, independent, consumer in rt and in both.
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); adv();
    drive(1, 0, 0, 5, 1, 7, 0, 0, 0);
    chk("rt sel", int'(srt[0]), 2);
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); adv();
    drive(1, 5, 1, 5, 1, 7, 0, 0, 0);
    chk("both rs", int'(srs[0]), 2);
    chk("both rt", int'(srt[0]), 2);
    adv();
    // Two writes to r2 in flight: youngest wins.
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0); adv();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0); adv();
    drive(1, 2, 1, 0, 0, 3, 0, 0, 0);
    chk("youngest sel", int'(srs[0]), 1);
    adv();
    // No forwarding: DEPTH stall cycles then register file.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); adv();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
      chk("nofwd stall", int'(rdy[1]), 0);
      adv();
    end
    chk("nofwd cnt", int'(cnt[1]), 3);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("nofwd ready", int'(rdy[1]), 1);
    chk("nofwd sel", int'(srs[1]), 0);
    adv();
    // Flush during a stall does not count.
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); adv();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 1);
    chk("flush stall", int'(rdy[0]), 0);
    adv();
    chk("flush cnt", int'(cnt[0]), 0);
    // Reset mid-stall.
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0); adv();
    rst = 1;
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0); adv();
    rst = 0;
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0);
    chk("rst ready", int'(rdy[0]), 1);
    chk("rst cnt", int'(cnt[0]), 0);
    adv();
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            3'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
      adv();
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
